// File: rtl/led_scan_driver.sv
// led_scan_driver: raster scan engine that shifts, latches and displays one LED panel row at a time
module led_scan_driver #(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int CLK_DIV = 2,
  parameter int DISP_CYCLES = 256,
  parameter logic [2:0] COLOR1 = 3'b100,
  parameter logic [2:0] COLOR2 = 3'b010,
  parameter logic [2:0] COLOR3 = 3'b001,
  parameter logic [2:0] COLOR_BG = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       judge1,
  input  logic       judge2,
  input  logic       judge3,
  output logic [6:0] row_now,
  output logic [6:0] col_now,
  output logic [2:0] led_rgb,
  output logic       led_sclk,
  output logic       led_lat,
  output logic       led_oe_n,
  output logic [6:0] row_addr,
  output logic       frame_done
);
  localparam int SW = $clog2(2 * CLK_DIV);
  localparam int DW = $clog2(DISP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;
  state_t state, state_d;
  logic [SW-1:0] s, s_d;
  logic [DW-1:0] d, d_d;
  logic [6:0] row_d, col_d, addr_d;
  logic [2:0] rgb_d;
  logic done_d, slot_end, col_last, row_end;
  always_comb begin
    slot_end = s == SW'(2 * CLK_DIV - 1);
    col_last = col_now == 7'(COLS - 1);
    row_end = d == DW'(DISP_CYCLES - 1);
    state_d = state;
    s_d = s;
    d_d = d;
    row_d = row_now;
    col_d = col_now;
    addr_d = row_addr;
    rgb_d = led_rgb;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        s_d = '0;
        state_d = en ? SHIFT : IDLE;
      end
      SHIFT: begin
        s_d = slot_end ? '0 : s + 1'b1;
        rgb_d = (s != '0) ? led_rgb : judge1 ? COLOR1 : judge2 ? COLOR2 : judge3 ? COLOR3 : COLOR_BG;
        col_d = !slot_end ? col_now : col_last ? '0 : col_now + 1'b1;
        state_d = (slot_end && col_last) ? LATCH : SHIFT;
      end
      LATCH: begin
        addr_d = row_now;
        d_d = '0;
        state_d = DISPLAY;
      end
      default: begin
        d_d = d + 1'b1;
        if (row_end) begin
          done_d = row_now == 7'(ROWS - 1);
          row_d = (!en || done_d) ? '0 : row_now + 1'b1;
          s_d = '0;
          state_d = en ? SHIFT : IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s <= '0;
      d <= '0;
      row_now <= '0;
      col_now <= '0;
      row_addr <= '0;
      led_rgb <= '0;
      led_sclk <= 1'b0;
      led_lat <= 1'b0;
      led_oe_n <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      s <= s_d;
      d <= d_d;
      row_now <= row_d;
      col_now <= col_d;
      row_addr <= addr_d;
      led_rgb <= rgb_d;
      led_sclk <= state_d == SHIFT && s_d >= SW'(CLK_DIV);
      led_lat <= state_d == LATCH;
      led_oe_n <= state_d != DISPLAY;
      frame_done <= done_d;
    end
  end
endmodule

// File: tb/tb_led_scan_driver.sv
// tb_led_scan_driver: scoreboard bench for led_scan_driver with 8 rows, 4 columns, 8-cycle display
module tb_led_scan_driver;
  logic clk, rst_n, en, judge1, judge2, judge3, glitch;
  logic [6:0] row_now, col_now, row_addr;
  logic [2:0] led_rgb;
  logic led_sclk, led_lat, led_oe_n, frame_done;
  int tests = 0, fails = 0, cyc = 0, n, c0;
  logic [16:0] rgb_q[$];
  int addr_q[$];
  int fd_q[$];
  logic prev_sclk, prev_oe;
  int oe_run, sclk_run, lat_run;
  logic [2:0] flags[3][4] = '{'{3'b000, 3'b100, 3'b000, 3'b001},
                              '{3'b111, 3'b011, 3'b010, 3'b001},
                              '{3'b000, 3'b010, 3'b101, 3'b000}};
  logic [2:0] exp_rgb[3][4] = '{'{3'b000, 3'b100, 3'b000, 3'b001},
                                '{3'b100, 3'b010, 3'b010, 3'b001},
                                '{3'b000, 3'b010, 3'b100, 3'b000}};
  led_scan_driver #(.ROWS(8), .COLS(4), .CLK_DIV(2), .DISP_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .judge1(judge1), .judge2(judge2), .judge3(judge3),
    .row_now(row_now), .col_now(col_now), .led_rgb(led_rgb), .led_sclk(led_sclk),
    .led_lat(led_lat), .led_oe_n(led_oe_n), .row_addr(row_addr), .frame_done(frame_done)
  );
  // judge2 toggles with led_sclk in row 2 col 0, i.e. only after the s=0 sample
  assign glitch = row_now == 7'd2 && col_now == 7'd0 && led_sclk;
  assign {judge1, judge2, judge3} = flags[int'(row_now) % 3][col_now[1:0]] | {1'b0, glitch, 1'b0};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  task automatic push_row(input int r);
    for (int c = 0; c < 4; c++) rgb_q.push_back({7'(r), 7'(c), exp_rgb[r % 3][c]});
    addr_q.push_back(r);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk <= 1'b0;
      prev_oe <= 1'b1;
      oe_run <= 0;
      sclk_run <= 0;
      lat_run <= 0;
    end else begin
      if (led_sclk && !prev_sclk) begin
        if (rgb_q.size() == 0) chk("sclk_unexpected", 32'(rgb_q.size()), 1);
        else chk("rgb", {row_now, col_now, led_rgb}, rgb_q.pop_front());
      end
      if (!led_oe_n && prev_oe) begin
        if (addr_q.size() == 0) chk("display_unexpected", 32'(addr_q.size()), 1);
        else chk("row_addr", row_addr, addr_q.pop_front());
      end
      if (frame_done) begin
        if (fd_q.size() == 0) chk("frame_done_unexpected", 32'(fd_q.size()), 1);
        else chk("frame_done_cycle", cyc, fd_q.pop_front());
      end
      if (led_lat) begin
        chk("lat_vs_oe", led_oe_n, 1);
        chk("lat_vs_sclk", led_sclk, 0);
      end
      if (led_oe_n && oe_run > 0) chk("oe_low_len", oe_run, 8);
      if (!led_sclk && sclk_run > 0) chk("sclk_high_len", sclk_run, 2);
      if (!led_lat && lat_run > 0) chk("lat_len", lat_run, 1);
      oe_run <= led_oe_n ? 0 : oe_run + 1;
      sclk_run <= led_sclk ? sclk_run + 1 : 0;
      lat_run <= led_lat ? lat_run + 1 : 0;
      prev_sclk <= led_sclk;
      prev_oe <= led_oe_n;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1;
    en = 0;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", led_oe_n, 1);
    chk("rst_row_now", row_now, 0);
    chk("rst_col_now", col_now, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_rgb", led_rgb, 0);
    chk("rst_sclk", led_sclk, 0);
    chk("rst_lat", led_lat, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("idle_oe_n", led_oe_n, 1);
    for (int r = 0; r < 8; r++) push_row(r);
    push_row(0);
    push_row(1);
    en = 1;
    c0 = cyc + 1;
    fd_q.push_back(c0 + 200);
    n = 0;
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    n = 0;
    while (!(row_now == 7'd1 && col_now == 7'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_row1_shift", 32'(n < 100), 1);
    en = 0;
    n = 0;
    while (led_oe_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("row1_displays", led_oe_n, 0);
    n = 0;
    while (!led_oe_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drop_oe_n", led_oe_n, 1);
    chk("drop_row_now", row_now, 0);
    chk("drop_col_now", col_now, 0);
    repeat (40) @(negedge clk);
    chk("drop_rgb_q_empty", 32'(rgb_q.size()), 0);
    chk("drop_addr_q_empty", 32'(addr_q.size()), 0);
    for (int r = 0; r < 6; r++) push_row(r);
    en = 1;
    n = 0;
    while (!(row_addr == 7'd5 && !led_oe_n) && n < 250) begin
      @(negedge clk);
      n++;
    end
    chk("reach_row5_display", 32'(n < 250), 1);
    repeat (2) @(negedge clk);
    chk("mid_display_row_now", row_now, 5);
    chk("mid_display_oe_n", led_oe_n, 0);
    #2 rst_n = 0;
    #1;
    chk("async_oe_n", led_oe_n, 1);
    chk("async_row_now", row_now, 0);
    chk("async_sclk", led_sclk, 0);
    chk("async_lat", led_lat, 0);
    chk("async_row_addr", row_addr, 0);
    en = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("post_rst_oe_n", led_oe_n, 1);
    chk("post_rst_col_now", col_now, 0);
    chk("post_rst_sclk", led_sclk, 0);
    chk("post_rst_q_empty", 32'(rgb_q.size() + addr_q.size()), 0);
    push_row(0);
    en = 1;
    n = 0;
    while (led_oe_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("restart_displays", led_oe_n, 0);
    en = 0;
    repeat (30) @(negedge clk);
    chk("restart_idle_oe_n", led_oe_n, 1);
    chk("final_rgb_q_empty", 32'(rgb_q.size()), 0);
    chk("final_addr_q_empty", 32'(addr_q.size()), 0);
    chk("final_fd_q_empty", 32'(fd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
